conversor_bin2bcd: RTL and testbench

CONVERSOR_BIN2BCD -- requirements
Module: conversor_bin2bcd

---
 rtl/conversor_bin2bcd.sv | 123 ++++++++++++
 tb/tb_conversor_bin2bcd.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conversor_bin2bcd.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (double dabble, one bit per clock).
// Optional two's-complement input with sign output: define BIN2BCD_SIGNO_EN.
module conversor_bin2bcd (
  input  logic        reloj,
  input  logic        reset,
  input  logic        inicio,
  input  logic [15:0] binario,
  output logic [19:0] bcd,
  output logic        ocupado,
  output logic        listo
`ifdef BIN2BCD_SIGNO_EN
  ,
  output logic        negativo
`endif
);
  localparam int NUM_DIG = 5;
  localparam int DIG_W   = 4;
  localparam int OP_W    = 16;

  typedef enum logic {REPOSO = 1'b0, CONVIERTE = 1'b1} estado_t;

  estado_t                        estado_q, estado_d;
  logic [4:0]                     cnt_q, cnt_d;
  logic [OP_W-1:0]                sr_q, sr_d;
  logic [NUM_DIG-1:0][DIG_W-1:0]  scr_q, scr_d, scr_adj;
  logic [NUM_DIG*DIG_W-1:0]       scr_adj_flat;
  logic [NUM_DIG*DIG_W-1:0]       bcd_q, bcd_d;
  logic                           listo_q, listo_d;
  logic                           ocupado_q, ocupado_d;
  logic [OP_W-1:0]                mag;

  // Pre-shift correction: any digit >= 5 would overflow past 9 once doubled.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    assign scr_adj[g] = (scr_q[g] >= 4'd5) ? scr_q[g] + 4'd3 : scr_q[g];
  end
  assign scr_adj_flat = scr_adj;

`ifdef BIN2BCD_SIGNO_EN
  logic signo_q, signo_d;
  logic neg_q, neg_d;
  // 0x8000 negates to itself, which read unsigned is the correct magnitude 32768.
  assign mag      = binario[OP_W-1] ? (~binario + 16'd1) : binario;
  assign negativo = neg_q;
`else
  assign mag = binario;
`endif

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    scr_d     = scr_q;
    bcd_d     = bcd_q;
    listo_d   = 1'b0;
    ocupado_d = ocupado_q;
`ifdef BIN2BCD_SIGNO_EN
    signo_d   = signo_q;
    neg_d     = neg_q;
`endif
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          sr_d      = mag;
          scr_d     = '0;
          cnt_d     = 5'd16;
          ocupado_d = 1'b1;
          estado_d  = CONVIERTE;
`ifdef BIN2BCD_SIGNO_EN
          signo_d   = binario[OP_W-1];
`endif
        end
      end
      CONVIERTE: begin
        scr_d = {scr_adj_flat[NUM_DIG*DIG_W-2:0], sr_q[OP_W-1]};
        sr_d  = {sr_q[OP_W-2:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          bcd_d     = {scr_adj_flat[NUM_DIG*DIG_W-2:0], sr_q[OP_W-1]};
          listo_d   = 1'b1;
          ocupado_d = 1'b0;
          estado_d  = REPOSO;
`ifdef BIN2BCD_SIGNO_EN
          neg_d     = signo_q;
`endif
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q  <= REPOSO;
      cnt_q     <= '0;
      sr_q      <= '0;
      scr_q     <= '0;
      bcd_q     <= '0;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
`ifdef BIN2BCD_SIGNO_EN
      signo_q   <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      scr_q     <= scr_d;
      bcd_q     <= bcd_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
`ifdef BIN2BCD_SIGNO_EN
      signo_q   <= signo_d;
      neg_q     <= neg_d;
`endif
    end
  end

  assign bcd     = bcd_q;
  assign listo   = listo_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_conversor_bin2bcd.sv
// Scoreboard bench for conversor_bin2bcd; the monitor checks every listo against a queued decimal model.
module tb_conversor_bin2bcd;
  logic        reloj = 1'b0;
  logic        reset;
  logic        inicio;
  logic [15:0] binario;
  logic [19:0] bcd;
  logic        ocupado;
  logic        listo;
`ifdef BIN2BCD_SIGNO_EN
  logic        negativo;
`endif

  conversor_bin2bcd dut (
    .reloj   (reloj),
    .reset   (reset),
    .inicio  (inicio),
    .binario (binario),
    .bcd     (bcd),
    .ocupado (ocupado),
    .listo   (listo)
`ifdef BIN2BCD_SIGNO_EN
    ,
    .negativo(negativo)
`endif
  );

  always #5 reloj = ~reloj;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        rst_at_edge = 1'b0;
  logic        mon_en = 1'b0;
  logic        listo_prev = 1'b0;
  logic [19:0] last_bcd = '0;
  logic        last_neg = 1'b0;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned magnitude(input logic [15:0] v);
`ifdef BIN2BCD_SIGNO_EN
    int s;
    s = (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    return (s < 0) ? int'(-s) : int'(s);
`else
    return int'(v);
`endif
  endfunction

  function automatic logic sign_of(input logic [15:0] v);
`ifdef BIN2BCD_SIGNO_EN
    return v >= 16'h8000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(posedge reloj) begin
    cyc <= cyc + 1;
    rst_at_edge = reset;
  end

  // Monitor: pops on every listo; otherwise bcd must hold its last result.
  always @(negedge reloj) begin
    if (mon_en) begin
      if (rst_at_edge) begin
        last_bcd   = '0;
        last_neg   = 1'b0;
        listo_prev = 1'b0;
      end else begin
        if (listo) begin
          chk("listo_width", {31'd0, listo_prev}, 32'd0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_listo: got bcd %h, required no completion", bcd);
          end else begin
            exp_t e;
            logic digits_ok;
            e = exp_q.pop_front();
            chk("bcd_value", {12'd0, bcd}, {12'd0, e.bcd});
            chk("latency", cyc, e.cyc);
`ifdef BIN2BCD_SIGNO_EN
            chk("negativo", {31'd0, negativo}, {31'd0, e.neg});
`endif
            digits_ok = 1'b1;
            for (int i = 0; i < 5; i++)
              if (bcd[4*i +: 4] > 4'd9) digits_ok = 1'b0;
            chk("digit_range", {31'd0, digits_ok}, 32'd1);
          end
          last_bcd = bcd;
`ifdef BIN2BCD_SIGNO_EN
          last_neg = negativo;
`endif
        end else begin
          chk("bcd_hold", {12'd0, bcd}, {12'd0, last_bcd});
`ifdef BIN2BCD_SIGNO_EN
          chk("neg_hold", {31'd0, negativo}, {31'd0, last_neg});
`endif
        end
        listo_prev = listo;
      end
    end
  end

  // Called at a negedge with the DUT idle or in its listo cycle; returns at the next listo cycle.
  task automatic convert(input logic [15:0] v, input int glitch);
    exp_t e;
    logic busy_ok;
    inicio  = 1'b1;
    binario = v;
    @(posedge reloj);
    @(negedge reloj);
    e.bcd = to_bcd(magnitude(v));
    e.neg = sign_of(v);
    e.cyc = cyc + 16;
    exp_q.push_back(e);
    inicio  = 1'b0;
    binario = 16'($urandom);
    busy_ok = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge reloj);
      if (ocupado !== 1'b1) busy_ok = 1'b0;
      inicio = (k == glitch);
      if (k == glitch) binario = 16'hBEEF;
    end
    chk("ocupado_busy", {31'd0, busy_ok}, 32'd1);
    @(negedge reloj);
    inicio = 1'b0;
    chk("ocupado_done", {31'd0, ocupado}, 32'd0);
  endtask

  task automatic idle(input int n);
    inicio = 1'b0;
    repeat (n) @(negedge reloj);
  endtask

  initial begin
    reset   = 1'b1;
    inicio  = 1'b0;
    binario = '0;
    repeat (3) @(negedge reloj);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_listo", {31'd0, listo}, 32'd0);
    chk("rst_bcd", {12'd0, bcd}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    convert(16'd0, 0);
    idle(1);
`ifdef BIN2BCD_SIGNO_EN
    convert(16'hFFFF, 0);
    convert(16'h8000, 0);
    convert(16'h7FFF, 0);
`else
    convert(16'd65535, 0);
`endif
    convert(16'd12345, 0);
    convert(16'd9, 0);
    idle(3);

    // Re-pulse at iteration 5 must be ignored; next start lands in the listo cycle.
    convert(16'd4321, 5);
    convert(16'd100, 0);
    idle(3);

    // Reset mid-conversion, with inicio also high to check reset priority.
    inicio  = 1'b1;
    binario = 16'd999;
    @(posedge reloj);
    @(negedge reloj);
    inicio = 1'b0;
    repeat (7) @(negedge reloj);
    reset   = 1'b1;
    inicio  = 1'b1;
    binario = 16'd555;
    @(posedge reloj);
    @(negedge reloj);
    chk("midrst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("midrst_listo", {31'd0, listo}, 32'd0);
    chk("midrst_bcd", {12'd0, bcd}, 32'd0);
    reset = 1'b0;
    idle(30);
    chk("midrst_no_listo", exp_q.size(), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      convert(16'($urandom), 0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    idle(20);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
